gf180mcu_ocd_io__brkxfer_rx: RTL

Receive end of the 4-phase REQ/ACK word transfer that carries control data across a pad-ring domain break.
- The far-side transmitter drives REQ, DATA and PAR. This block synchronises REQ, captures DATA, returns ACK, and presents words to local logic through a 2-entry valid/ready buffer.
- It also checks parity and counts parity errors.
- It sits in the pad ring immediately on the local side of a break cell.

---
 rtl/gf180mcu_ocd_io__brkxfer_rx.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/gf180mcu_ocd_io__brkxfer_rx.sv
// Receive side of the 4-phase REQ/ACK word transfer across a pad-ring domain break.
// Synchronises REQ, captures DATA/PAR, returns ACK and buffers words in a 2-entry FIFO.
module gf180mcu_ocd_io__brkxfer_rx #(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned SYNC_STAGES = 2,
  parameter bit          PARITY_EN   = 1'b1
) (
  input  logic             CLK,
  input  logic             RST,
  inout  wire              VDD,
  inout  wire              VSS,
  input  logic             REQ,
  input  logic [WIDTH-1:0] DATA,
  input  logic             PAR,
  output logic             ACK,
  output logic [WIDTH-1:0] OUT_DATA,
  output logic             OUT_VALID,
  input  logic             OUT_READY,
  output logic             PERR,
  input  logic             PERR_CLR,
  output logic [7:0]       ERR_CNT
);

  typedef enum logic {StIdle, StHold} state_e;

  state_e           state_q, state_d;
  logic             ack_q;
  logic [SYNC_STAGES-1:0] sync_q;
  logic             req_s;
  logic             capture;
  logic             parity_bad;
  logic             push, pop, full;
  logic [1:0]       count_q, count_d;
  logic [WIDTH-1:0] head_q, head_d, tail_q, tail_d;
  logic             perr_q, perr_d;
  logic [7:0]       cnt_q, cnt_d;
  logic             unused_supply;

  // Supplies are pass-through pins only.
  assign unused_supply = VDD ^ VSS;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], REQ};
    end
  end

  assign req_s      = sync_q[SYNC_STAGES-1];
  assign full       = (count_q == 2'd2);
  assign parity_bad = PARITY_EN && (^{DATA, PAR});
  assign push       = capture && !parity_bad;
  assign pop        = OUT_VALID && OUT_READY;

  always_comb begin
    state_d = state_q;
    capture = 1'b0;
    unique case (state_q)
      StIdle: begin
        // A full buffer holds the transmitter off by withholding ACK.
        if (req_s && !full) begin
          capture = 1'b1;
          state_d = StHold;
        end
      end
      StHold: begin
        if (!req_s) begin
          state_d = StIdle;
        end
      end
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= StIdle;
      ack_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ack_q   <= (state_d == StHold);
    end
  end

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    unique case ({push, pop})
      2'b10: begin
        if (count_q == 2'd0) begin
          head_d = DATA;
        end else begin
          tail_d = DATA;
        end
        count_d = count_q + 2'd1;
      end
      2'b01: begin
        if (count_q == 2'd2) begin
          head_d = tail_q;
        end
        count_d = count_q - 2'd1;
      end
      // Only reachable with one entry: the new word replaces the departing head.
      2'b11: head_d = DATA;
      default: ;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= 2'd0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  always_comb begin
    perr_d = perr_q;
    cnt_d  = cnt_q;
    if (PERR_CLR) begin
      perr_d = 1'b0;
      cnt_d  = 8'd0;
    end
    // An error on the clearing edge still counts.
    if (capture && parity_bad) begin
      perr_d = 1'b1;
      if (cnt_d != 8'hFF) begin
        cnt_d = cnt_d + 8'd1;
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      perr_q <= 1'b0;
      cnt_q  <= 8'd0;
    end else begin
      perr_q <= perr_d;
      cnt_q  <= cnt_d;
    end
  end

  assign ACK       = ack_q;
  assign OUT_DATA  = head_q;
  assign OUT_VALID = (count_q != 2'd0);
  assign PERR      = perr_q;
  assign ERR_CNT   = cnt_q;

endmodule
